// File: rtl/div_seq_64bit.sv
// Sequential 64-bit signed/unsigned divider: one shared subtractor, restoring
// division one bit per cycle, fixed 68-cycle latency from accepted start to done.

module add_sub_64bit (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        mode,
    output logic [63:0] s,
    output logic        cout
);
    logic [64:0] sum;

    // mode=1 computes a + ~b + 1; carry out then means a >= b (unsigned)
    assign sum  = {1'b0, a} + {1'b0, (mode ? ~b : b)} + 65'(mode);
    assign s    = sum[63:0];
    assign cout = sum[64];
endmodule

module div_seq_64bit #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);
    localparam int unsigned CNT_W = 6;

    typedef enum logic [2:0] {
        IDLE,
        NEG_A,
        NEG_B,
        ITER,
        FIX_Q,
        FIX_R,
        DONE
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] r_reg, r_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             sa, sa_next;
    logic             sb, sb_next;
    logic             busy_next, done_next;
    logic [WIDTH-1:0] quotient_next, remainder_next;
    logic             div_zero_next;

    logic [WIDTH-1:0] add_a, add_b, add_s;
    logic             add_cout;
    logic [WIDTH-1:0] shifted;
    logic             take;

    add_sub_64bit u_add_sub (
        .a    (add_a),
        .b    (add_b),
        .s    (add_s),
        .cout (add_cout),
        .mode (1'b1)
    );

    // Partial remainder shifted left with the next dividend bit from Q
    assign shifted = {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};
    assign take    = r_reg[WIDTH-1] | add_cout;

    // State register and all datapath/output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            q_reg     <= '0;
            r_reg     <= '0;
            b_reg     <= '0;
            cnt       <= '0;
            sa        <= 1'b0;
            sb        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            state     <= state_next;
            q_reg     <= q_next;
            r_reg     <= r_next;
            b_reg     <= b_next;
            cnt       <= cnt_next;
            sa        <= sa_next;
            sb        <= sb_next;
            busy      <= busy_next;
            done      <= done_next;
            quotient  <= quotient_next;
            remainder <= remainder_next;
            div_zero  <= div_zero_next;
        end
    end

    // Next-state, adder operand steering and register updates
    always_comb begin
        state_next     = state;
        q_next         = q_reg;
        r_next         = r_reg;
        b_next         = b_reg;
        cnt_next       = cnt;
        sa_next        = sa;
        sb_next        = sb;
        quotient_next  = quotient;
        remainder_next = remainder;
        div_zero_next  = div_zero;
        add_a          = '0;
        add_b          = '0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    q_next        = dividend;
                    b_next        = divisor;
                    sa_next       = signed_op & dividend[WIDTH-1];
                    sb_next       = signed_op & divisor[WIDTH-1];
                    div_zero_next = (divisor == '0);
                    state_next    = NEG_A;
                end
            end
            NEG_A: begin
                add_b = q_reg;
                if (sa) q_next = add_s;
                state_next = NEG_B;
            end
            NEG_B: begin
                add_b = b_reg;
                if (sb) b_next = add_s;
                r_next     = '0;
                cnt_next   = CNT_W'(WIDTH - 1);
                state_next = ITER;
            end
            ITER: begin
                add_a  = shifted;
                add_b  = b_reg;
                r_next = take ? add_s : shifted;
                q_next = {q_reg[WIDTH-2:0], take};
                if (cnt == '0) begin
                    state_next = FIX_Q;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            FIX_Q: begin
                add_b         = q_reg;
                quotient_next = ((sa ^ sb) & ~div_zero) ? add_s : q_reg;
                state_next    = FIX_R;
            end
            FIX_R: begin
                add_b          = r_reg;
                remainder_next = sa ? add_s : r_reg;
                state_next     = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE) && (state_next != DONE);
        done_next = (state_next == DONE);
    end
endmodule

// File: doc/div_seq_64bit.md
Name: div_seq_64bit

Overview:
- Multi-cycle 64-bit integer divider controller built around a single shared add_sub_64bit instance (a, b, s, cout, mode).
- Sequences that adder through operand negation, 64 restoring-division iterations and result sign correction.
- Produces quotient and remainder with fixed latency and a start/busy/done handshake.
- Sits beside the ALU as its DIV/DIVU/REM/REMU execution unit.

Parameters:
- WIDTH, 64, operand width. Only 64 is supported because add_sub_64bit is fixed-width.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request. Sampled only in IDLE.
- signed_op  input  1  1 = signed (two's complement) division, 0 = unsigned. Latched at start.
- dividend  input  64  dividend. Latched at start.
- divisor  input  64  divisor. Latched at start.
- busy  output  1  high in every state except IDLE and DONE.
- done  output  1  one-cycle pulse; quotient, remainder and div_zero are valid from this cycle.
- quotient  output  64  result quotient. Held until the next accepted start.
- remainder  output  64  result remainder. Held until the next accepted start.
- div_zero  output  1  latched divisor == 0 flag for the current result.

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE.
  - busy=0, done=0, quotient=0, remainder=0, div_zero=0.
  - All internal registers are cleared.
  - Reset asserted mid-operation abandons the operation; no done is issued.
- Adder usage:
  - Exactly one add_sub_64bit instance, always driven with mode=1 (a + ~b + 1).
  - Its cout=1 exactly when a >= b (unsigned).
  - Negation of x is computed as a=0, b=x.
- States: IDLE, NEG_A, NEG_B, ITER, FIX_Q, FIX_R, DONE.
- IDLE:
  - On start=1, latch the operands, signed_op and div_zero=(divisor==0).
  - Set sa = signed_op & dividend[63] and sb = signed_op & divisor[63].
  - Go to NEG_A.
- NEG_A: A_mag = sa ? (0 - A) : A. Go to NEG_B.
- NEG_B:
  - B_mag = sb ? (0 - B) : B.
  - Clear R=0, Q=A_mag, counter=63.
  - Go to ITER.
- ITER, one bit per cycle, 64 cycles:
  - t = {R[62:0], Q[63]}; adder a=t, b=B_mag.
  - take = R[63] | cout.
  - R <= take ? s : t.
  - Q <= {Q[62:0], take}.
  - On counter==0 go to FIX_Q; otherwise decrement the counter.
- FIX_Q:
  - If (sa ^ sb) & ~div_zero, quotient <= 0 - Q; otherwise quotient <= Q.
  - Go to FIX_R.
- FIX_R:
  - If sa, remainder <= 0 - R; otherwise remainder <= R.
  - Go to DONE.
- DONE:
  - done=1 for exactly this cycle, busy=0.
  - Go to IDLE unconditionally; start in DONE is ignored.
- Latency:
  - start sampled at edge N gives state NEG_A after N, ITER after N+2 through N+65, FIX_Q after N+66, FIX_R after N+67, DONE after N+68.
  - done is high for one cycle, 68 cycles after acceptance, independent of operand values.
  - Throughput is one operation per 70 cycles (back-to-back start is accepted in IDLE).
- start while busy or in DONE: ignored. Latched operands are unaffected by input changes after acceptance.
- Divide by zero:
  - Falls out naturally: every subtract succeeds.
  - Unsigned result: quotient = all ones, remainder = dividend.
  - Signed result: quotient = -1, remainder = dividend.
  - div_zero=1.
- Signed overflow, 0x8000_0000_0000_0000 / -1:
  - quotient = 0x8000_0000_0000_0000, remainder = 0.
  - No flag is raised.
- Sign rules: quotient truncates toward zero; remainder takes the sign of the dividend.
- quotient, remainder and div_zero change only in FIX_Q, FIX_R or IDLE-accept (div_zero only) and under reset.

Test Plan:
- Unsigned 100 / 7, start held for 1 cycle:
  - busy rises the next cycle.
  - done is high exactly 68 cycles after acceptance.
  - quotient=14, remainder=2, div_zero=0.
- Signed -7 / 2 gives quotient=0xFFFF_FFFF_FFFF_FFFD, remainder=0xFFFF_FFFF_FFFF_FFFF.
- Signed 7 / -2 gives quotient=0xFFFF_FFFF_FFFF_FFFD, remainder=1.
- Divide by zero:
  - Unsigned 5 / 0 gives quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=5, div_zero=1.
  - Signed -5 / 0 gives quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=0xFFFF_FFFF_FFFF_FFFB, div_zero=1.
- Edge cases:
  - Signed 0x8000_0000_0000_0000 / -1 gives quotient=0x8000_0000_0000_0000, remainder=0.
  - Unsigned 0xFFFF_FFFF_FFFF_FFFF / 1 gives quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=0 (exercises the R[63] take path).
  - Unsigned 0xFFFF_FFFF_FFFF_FFFF / 0x8000_0000_0000_0001 gives quotient=1, remainder=0x7FFF_FFFF_FFFF_FFFE.
  - A second start pulse at cycle 20 of a busy operation is ignored: the result is unchanged and only one done is seen.
- Reset mid-operation:
  - Start 1000 / 10; assert rst asynchronously (between clock edges) during ITER, 30 cycles after acceptance.
  - busy, done, quotient, remainder and div_zero go to 0 without waiting for a clock edge.
  - After rst is released, unsigned 1000 / 10 yields quotient=100, remainder=0 with 68-cycle latency.
